// File: rtl/tmds_word_align_if.sv
// Bundle between the 10:1 deserializer/decoder side and the TMDS word aligner.
// The aligner takes the slave view; the driving/observing side takes master.
interface tmds_word_align_if;
  logic [9:0] raw;
  logic [9:0] dout;
  logic       aligned;
  logic [3:0] offset;
  logic       lock_lost;

  modport master (output raw, input dout, input aligned, input offset, input lock_lost);
  modport slave  (input raw, output dout, output aligned, output offset, output lock_lost);
endinterface

// File: rtl/tmds_word_align.sv
// TMDS word aligner: searches the ten bit offsets of the deserializer stream for
// repeated control tokens, locks onto the offset producing them, and tracks loss.
module tmds_word_align #(
  parameter int HIT_THRESHOLD  = 16,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input logic            clk,
  input logic            rst,
  tmds_word_align_if.slave bus
);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  localparam logic [7:0]  HIT_LAST    = 8'(HIT_THRESHOLD - 1);
  localparam logic [12:0] SEARCH_LAST = 13'(SEARCH_TIMEOUT - 1);
  localparam logic [12:0] LOSS_LAST   = 13'(LOSS_TIMEOUT - 1);

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'b1101010100) || (w == 10'b0010101011) ||
           (w == 10'b0101010100) || (w == 10'b1010101011);
  endfunction

  logic [9:0]  cur_p0;
  logic [9:0]  prev_p1;
  logic [9:0]  dout_p2;
  logic [19:0] hist;
  logic [9:0]  win;
  logic        tok;
  logic [0:0]  state;
  logic [3:0]  offset_r;
  logic [7:0]  hit_cnt;
  logic [12:0] timer;
  logic        lock_lost_r;

  // prev holds the older word, so bit 0 of hist is the earliest serial bit
  assign hist = {cur_p0, prev_p1};
  assign win  = 10'(hist >> offset_r);
  assign tok  = is_token(win);

  // stage p0/p1: deserializer word history
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_p0  <= '0;
      prev_p1 <= '0;
    end else begin
      cur_p0  <= bus.raw;
      prev_p1 <= cur_p0;
    end
  end

  // stage p2: framed symbol out, registered in both states
  always_ff @(posedge clk) begin
    if (rst) dout_p2 <= '0;
    else     dout_p2 <= win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_SEARCH;
      offset_r    <= 4'd0;
      hit_cnt     <= 8'd0;
      timer       <= 13'd0;
      lock_lost_r <= 1'b0;
    end else begin
      lock_lost_r <= 1'b0;
      if (state == S_SEARCH) begin
        // a lock on the timeout edge takes priority, so the offset holds
        if (tok && (hit_cnt == HIT_LAST)) begin
          state   <= S_LOCKED;
          hit_cnt <= 8'd0;
          timer   <= 13'd0;
        end else if (timer == SEARCH_LAST) begin
          offset_r <= (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
          hit_cnt  <= 8'd0;
          timer    <= 13'd0;
        end else begin
          hit_cnt <= tok ? hit_cnt + 8'd1 : 8'd0;
          timer   <= timer + 13'd1;
        end
      end else begin
        if (tok) begin
          timer <= 13'd0;
        end else if (timer == LOSS_LAST) begin
          state       <= S_SEARCH;
          lock_lost_r <= 1'b1;
          hit_cnt     <= 8'd0;
          timer       <= 13'd0;
        end else begin
          timer <= timer + 13'd1;
        end
      end
    end
  end

  assign bus.dout      = dout_p2;
  assign bus.aligned   = (state == S_LOCKED);
  assign bus.offset    = offset_r;
  assign bus.lock_lost = lock_lost_r;

endmodule

// File: tb/tb_tmds_word_align.sv
// Directed bench for tmds_word_align with HIT_THRESHOLD=4, SEARCH_TIMEOUT=32,
// LOSS_TIMEOUT=32; edge counts below are relative to the first edge after reset.
module tb_tmds_word_align;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  localparam logic [9:0] TOK  = 10'b1101010100;
  localparam logic [9:0] NTOK = 10'h1F0;

  tmds_word_align_if bus ();

  tmds_word_align #(
    .HIT_THRESHOLD (4),
    .SEARCH_TIMEOUT(32),
    .LOSS_TIMEOUT  (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rotate left: the word stream seen when a token stream is delayed d serial bits
  function automatic logic [9:0] rotl(input logic [9:0] w, input int d);
    logic [19:0] t;
    t = {w, w};
    t = t << d;
    return t[19:10];
  endfunction

  // a run of four ones every word keeps every 10-bit window off the token set
  function automatic logic [9:0] rnd();
    return 10'($urandom) | 10'h00F;
  endfunction

  task automatic feed(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.raw = w;
      tick();
    end
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      bus.raw = rnd();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    noise(2);
    check_eq("rst_dout",      16'(bus.dout),      16'h0);
    check_eq("rst_offset",    16'(bus.offset),    16'h0);
    check_eq("rst_aligned",   16'(bus.aligned),   16'h0);
    check_eq("rst_lock_lost", 16'(bus.lock_lost), 16'h0);
    rst = 1'b0;
  endtask

  logic [9:0] r3;

  initial begin
    bus.raw = '0;
    r3 = rotl(TOK, 3);

    // reset, then non-token traffic must not lock
    do_reset();
    noise(20);
    check_eq("noise_aligned", 16'(bus.aligned), 16'h0);
    check_eq("noise_offset",  16'(bus.offset),  16'h0);

    // zero-offset lock: first token on dout after F3, lock at F6
    do_reset();
    feed(TOK, 2);
    check_eq("z_dout_f2",    16'(bus.dout),    16'h0);
    feed(TOK, 1);
    check_eq("z_dout_f3",    16'(bus.dout),    16'(TOK));
    check_eq("z_aligned_f3", 16'(bus.aligned), 16'h0);
    feed(TOK, 2);
    check_eq("z_aligned_f5", 16'(bus.aligned), 16'h0);
    feed(TOK, 1);
    check_eq("z_aligned_f6", 16'(bus.aligned), 16'h1);
    check_eq("z_offset_f6",  16'(bus.offset),  16'h0);
    feed(TOK, 10);
    check_eq("z_dout_hold",  16'(bus.dout),    16'(TOK));
    check_eq("z_aligned_hold", 16'(bus.aligned), 16'h1);

    // slip to offset 3: slips at F32/F64/F96, lock at F100
    do_reset();
    feed(r3, 31);
    check_eq("s_offset_f31", 16'(bus.offset), 16'h0);
    feed(r3, 1);
    check_eq("s_offset_f32", 16'(bus.offset), 16'h1);
    feed(r3, 32);
    check_eq("s_offset_f64", 16'(bus.offset), 16'h2);
    feed(r3, 32);
    check_eq("s_offset_f96",  16'(bus.offset),  16'h3);
    check_eq("s_aligned_f96", 16'(bus.aligned), 16'h0);
    feed(r3, 3);
    check_eq("s_aligned_f99", 16'(bus.aligned), 16'h0);
    check_eq("s_dout_f99",    16'(bus.dout),    16'(TOK));
    feed(r3, 1);
    check_eq("s_aligned_f100", 16'(bus.aligned), 16'h1);
    check_eq("s_dout_f100",    16'(bus.dout),    16'(TOK));

    // loss: first non-token window registered at G2, loss at G33
    feed(NTOK, 2);
    check_eq("l_dout_g2", 16'(bus.dout), 16'h054);
    feed(NTOK, 30);
    check_eq("l_aligned_g32",   16'(bus.aligned),   16'h1);
    check_eq("l_lock_lost_g32", 16'(bus.lock_lost), 16'h0);
    feed(NTOK, 1);
    check_eq("l_aligned_g33",   16'(bus.aligned),   16'h0);
    check_eq("l_lock_lost_g33", 16'(bus.lock_lost), 16'h1);
    check_eq("l_offset_g33",    16'(bus.offset),    16'h3);
    feed(r3, 1);
    check_eq("l_lock_lost_g34", 16'(bus.lock_lost), 16'h0);
    check_eq("l_aligned_g34",   16'(bus.aligned),   16'h0);
    feed(r3, 4);
    check_eq("r_aligned_g38", 16'(bus.aligned), 16'h0);
    feed(r3, 1);
    check_eq("r_aligned_g39", 16'(bus.aligned), 16'h1);
    check_eq("r_offset_g39",  16'(bus.offset),  16'h3);
    check_eq("r_dout_g39",    16'(bus.dout),    16'(TOK));

    // wrap-around: offset 9 after F288, wraps to 0 at F320, lock at F324
    do_reset();
    noise(288);
    check_eq("w_offset_f288", 16'(bus.offset), 16'h9);
    noise(22);
    feed(TOK, 9);
    check_eq("w_offset_f319",  16'(bus.offset),  16'h9);
    check_eq("w_aligned_f319", 16'(bus.aligned), 16'h0);
    feed(TOK, 1);
    check_eq("w_offset_f320", 16'(bus.offset), 16'h0);
    feed(TOK, 3);
    check_eq("w_aligned_f323", 16'(bus.aligned), 16'h0);
    feed(TOK, 1);
    check_eq("w_aligned_f324", 16'(bus.aligned), 16'h1);
    check_eq("w_offset_f324",  16'(bus.offset),  16'h0);

    // 4th token registered on F32, the same edge the search timer expires
    do_reset();
    noise(26);
    feed(TOK, 5);
    check_eq("c_aligned_f31", 16'(bus.aligned), 16'h0);
    check_eq("c_offset_f31",  16'(bus.offset),  16'h0);
    feed(TOK, 1);
    check_eq("c_aligned_f32", 16'(bus.aligned), 16'h1);
    check_eq("c_offset_f32",  16'(bus.offset),  16'h0);

    // reset mid-search at offset 5
    do_reset();
    noise(160);
    check_eq("m_offset_f160", 16'(bus.offset), 16'h5);
    noise(7);
    check_eq("m_offset_f167", 16'(bus.offset), 16'h5);
    rst = 1'b1;
    noise(1);
    check_eq("m_offset_rst",  16'(bus.offset),  16'h0);
    check_eq("m_aligned_rst", 16'(bus.aligned), 16'h0);
    check_eq("m_dout_rst",    16'(bus.dout),    16'h0);
    rst = 1'b0;
    noise(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
